// File: rtl/pic_fetch_ctrl.sv
// pic_fetch_ctrl: PC/IR fetch sequencer with local branch resolution
// and a circular hardware return stack.
module pic_fetch_ctrl #(
    parameter int          STACK_DEPTH  = 8,
    parameter logic [10:0] RESET_VECTOR = 11'h000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    input  logic        stall_in,
    input  logic        skip_in,
    output logic [13:0] ir_out,
    output logic        ir_valid,
    output logic [7:0]  retlw_k,
    output logic        is_retlw,
    output logic        stk_ovf,
    output logic        stk_unf
);
    localparam int SW = $clog2(STACK_DEPTH);
    localparam logic [SW:0] FULL = (SW+1)'(STACK_DEPTH);
    logic [10:0] pc, pc_n, tos;
    logic [13:0] ir_n;
    logic        v_n, is_goto, is_call, is_ret, flush, push, pop;
    logic [10:0] stack [STACK_DEPTH];
    logic [SW-1:0] sp;
    logic [SW:0]   cnt;
    assign Rom_addr_out = pc;
    assign retlw_k  = ir_out[7:0];
    assign is_retlw = ir_valid && ir_out[13:10] == 4'b1101;
    assign is_goto  = ir_valid && ir_out[13:11] == 3'b101;
    assign is_call  = ir_valid && ir_out[13:11] == 3'b100;
    assign is_ret   = is_retlw || (ir_valid && (ir_out == 14'h0008 || ir_out == 14'h0009));
    // a skip only flushes a real, non-branch instruction; branches flush on their own
    assign flush = is_goto || is_call || is_ret || (skip_in && ir_valid);
    assign push  = !stall_in && is_call;
    assign pop   = !stall_in && is_ret;
    assign tos   = stack[sp - SW'(1)];
    always_comb begin
        pc_n = (is_goto || is_call) ? ir_out[10:0] : is_ret ? tos : pc + 11'd1;
        ir_n = flush ? 14'h0000 : Rom_data_in;
        v_n  = !flush;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_VECTOR;
            ir_out   <= 14'h0000;
            ir_valid <= 1'b0;
            sp       <= '0;
            cnt      <= '0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
        end else if (!stall_in) begin
            pc       <= pc_n;
            ir_out   <= ir_n;
            ir_valid <= v_n;
            if (push) begin
                sp      <= sp + SW'(1);
                cnt     <= (cnt == FULL) ? cnt : cnt + (SW+1)'(1);
                stk_ovf <= stk_ovf || cnt == FULL;
            end
            if (pop) begin
                sp      <= sp - SW'(1);
                cnt     <= (cnt == '0) ? cnt : cnt - (SW+1)'(1);
                stk_unf <= stk_unf || cnt == '0;
            end
        end
    end
    // contents need no reset: only entries written by a push are meaningful
    always_ff @(posedge clk) begin
        if (push) stack[sp] <= pc;
    end
endmodule

// File: tb/tb_pic_fetch_ctrl.sv
// tb_pic_fetch_ctrl: directed table, hand-written corner sequences and
// randomized run against a behavioural fetch model.
module tb_pic_fetch_ctrl;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, skip = 1'b0;
    logic [10:0] rom_addr;
    logic [13:0] rom_data, ir;
    logic [7:0]  retlw_k;
    logic        ir_valid, is_retlw, ovf, unf;
    logic [13:0] rom [2048];
    int checks = 0, errors = 0;

    pic_fetch_ctrl dut (
        .clk(clk), .reset(reset), .Rom_addr_out(rom_addr), .Rom_data_in(rom_data),
        .stall_in(stall), .skip_in(skip), .ir_out(ir), .ir_valid(ir_valid),
        .retlw_k(retlw_k), .is_retlw(is_retlw), .stk_ovf(ovf), .stk_unf(unf)
    );

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 14'h0000;
    endtask

    typedef struct {
        logic        stall;
        logic        skip;
        logic [10:0] addr;
        logic [13:0] ir;
        logic        v;
    } vec_t;
    vec_t tbl [7];

    // behavioural model: stack as a ring indexed by net push count
    logic [10:0] m_pc;
    logic [13:0] m_ir;
    logic        m_v, m_ovf, m_unf;
    logic [10:0] m_stk [8];
    int          m_sp, m_cnt;

    task automatic model_reset();
        m_pc = 11'h000; m_ir = 14'h0000; m_v = 1'b0;
        m_sp = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sk, input logic [13:0] word);
        bit g, c, r;
        if (st) return;
        g = m_v && m_ir[13:11] == 3'b101;
        c = m_v && m_ir[13:11] == 3'b100;
        r = m_v && (m_ir == 14'h0008 || m_ir == 14'h0009 || m_ir[13:10] == 4'b1101);
        if (g) m_pc = m_ir[10:0];
        else if (c) begin
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % 8;
            if (m_cnt == 8) m_ovf = 1'b1; else m_cnt++;
            m_pc = m_ir[10:0];
        end else if (r) begin
            m_sp = (m_sp + 7) % 8;
            m_pc = m_stk[m_sp];
            if (m_cnt == 0) m_unf = 1'b1; else m_cnt--;
        end else m_pc = m_pc + 11'd1;
        if (g || c || r || (sk && m_v)) begin
            m_ir = 14'h0000; m_v = 1'b0;
        end else begin
            m_ir = word; m_v = 1'b1;
        end
    endtask

    function automatic logic [13:0] rnd_word();
        int r = $urandom_range(99);
        logic [13:0] w = 14'($urandom);
        if (r < 10) return {3'b101, w[10:0]};
        if (r < 20) return {3'b100, w[10:0]};
        if (r < 25) return 14'h0008;
        if (r < 28) return 14'h0009;
        if (r < 36) return {4'b1101, w[9:0]};
        return {2'b00, w[11:0]};
    endfunction

    initial begin
        // free-run then skip/stall table
        tbl[0] = '{1'b0, 1'b0, 11'h001, 14'h3001, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 11'h002, 14'h00B5, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 11'h003, 14'h3003, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 11'h004, 14'h0000, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 11'h005, 14'h0456, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 11'h005, 14'h0456, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 11'h006, 14'h0789, 1'b1};
        clear_rom();
        rom[0] = 14'h3001; rom[1] = 14'h00B5; rom[2] = 14'h3003;
        rom[3] = 14'h0123; rom[4] = 14'h0456; rom[5] = 14'h0789;
        do_reset();
        chk("rst_addr", rom_addr, 11'h000);
        chk("rst_ir", ir, 14'h0000);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_unf", unf, 1'b0);
        for (int i = 0; i < 7; i++) begin
            stall = tbl[i].stall;
            skip  = tbl[i].skip;
            step();
            chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_ir", i), ir, tbl[i].ir);
            chk($sformatf("tbl%0d_valid", i), ir_valid, tbl[i].v);
        end
        stall = 1'b0; skip = 1'b0;

        // GOTO 0x005 at address 7
        clear_rom();
        rom[7] = 14'h2805; rom[5] = 14'h0555;
        do_reset();
        repeat (8) step();
        chk("goto_ir", ir, 14'h2805);
        step();
        chk("goto_addr", rom_addr, 11'h005);
        chk("goto_bubble", ir_valid, 1'b0);
        step();
        chk("goto_target_ir", ir, 14'h0555);
        chk("goto_target_valid", ir_valid, 1'b1);

        // stall for 3 cycles with GOTO in IR
        do_reset();
        repeat (8) step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", rom_addr, 11'h008);
            chk("stall_ir", ir, 14'h2805);
        end
        stall = 1'b0;
        step();
        chk("stall_goto_addr", rom_addr, 11'h005);
        chk("stall_goto_bubble", ir_valid, 1'b0);
        step();
        chk("stall_goto_ir", ir, 14'h0555);

        // CALL 0x020 at 0x010, RETLW 0x00 at 0x020, then an extra RETURN
        clear_rom();
        rom[0] = 14'h2810; rom[11'h010] = 14'h2020;
        rom[11'h020] = 14'h3400; rom[11'h011] = 14'h0008;
        do_reset();
        repeat (5) step();
        chk("retlw_ir", ir, 14'h3400);
        chk("retlw_flag", is_retlw, 1'b1);
        chk("retlw_k", retlw_k, 8'h00);
        step();
        chk("ret_addr", rom_addr, 11'h011);
        chk("ret_bubble", ir_valid, 1'b0);
        chk("ret_bubble_retlw", is_retlw, 1'b0);
        step();
        chk("ret_next_ir", ir, 14'h0008);
        step();
        chk("empty_pop_unf", unf, 1'b1);
        chk("empty_pop_ovf", ovf, 1'b0);

        // nine nested CALLs then nine RETURNs
        clear_rom();
        for (int a = 0; a < 9; a++) rom[a] = 14'h2000 | 14'(a + 1);
        rom[9] = 14'h0008;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 16) chk("ovf_after_8", ovf, 1'b0);
        end
        chk("ovf_after_9", ovf, 1'b1);
        chk("call9_addr", rom_addr, 11'h009);
        for (int a = 0; a < 10; a++) rom[a] = 14'h0008;
        step();
        for (int j = 0; j < 9; j++) begin
            step();
            chk($sformatf("pop%0d_addr", j), rom_addr, (j < 8) ? 11'(9 - j) : 11'h009);
            if (j == 7) chk("unf_after_8_pops", unf, 1'b0);
            if (j == 8) chk("unf_after_9_pops", unf, 1'b1);
            step();
        end

        // asynchronous reset mid-sequence
        reset = 1'b1;
        #1;
        chk("async_rst_addr", rom_addr, 11'h000);
        chk("async_rst_ir", ir, 14'h0000);
        chk("async_rst_valid", ir_valid, 1'b0);
        chk("async_rst_ovf", ovf, 1'b0);
        chk("async_rst_unf", unf, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // PC wrap from 0x7FF
        clear_rom();
        rom[0] = 14'h2FFF; rom[11'h7FF] = 14'h0AAA;
        do_reset();
        step();
        step();
        chk("wrap_at_7ff", rom_addr, 11'h7FF);
        step();
        chk("wrap_ir", ir, 14'h0AAA);
        chk("wrap_addr", rom_addr, 11'h000);

        // randomized run; stack ring still holds the nested-call pushes
        foreach (rom[i]) rom[i] = rnd_word();
        m_stk = '{11'd9, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd8};
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            stall = ($urandom_range(4) == 0);
            skip  = ($urandom_range(2) == 0);
            model_step(stall, skip, rom[m_pc]);
            step();
            chk("rnd_addr", rom_addr, m_pc);
            chk("rnd_ir", ir, m_ir);
            chk("rnd_valid", ir_valid, m_v);
            chk("rnd_retlw", is_retlw, m_v && m_ir[13:10] == 4'b1101);
            chk("rnd_flags", {ovf, unf}, {m_ovf, m_unf});
        end
        stall = 1'b0; skip = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
